ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It sits between the execute stage and data memory, and carries ALU result, store data, destination register and MEM/WB control. Backpressure from memory stalls the stage without a combinational ready path back into EX. Invalid slots never issue memory reads, memory writes or writebacks.

---
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: main + skid register pair with valid/ready handshake and synchronous flush.
// Accepted entries reach the outputs one cycle later. ready_o is a registered state decode, independent of ready_i.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WB_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        MEM_i,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] ALUout_i,
    input  logic [DATA_W-1:0] RS2_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              MEMR_o,
    output logic              MEMW_o,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] ALUout_o,
    output logic [DATA_W-1:0] RS2_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [1:0]        occ_o
);

    typedef struct packed {
        logic [1:0]        mem;
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   in_fire, out_fire;

    assign in_ent  = '{mem: MEM_i, wb: WB_i, alu: ALUout_i, rs2: RS2_i, rd: RDaddr_i};
    assign ready_o = (state_q != S_FULL);
    assign valid_o = (state_q != S_EMPTY);
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Incoming entry is dropped; an out_fire this cycle has already been taken by MEM.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_ent;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_ent;
                    end else if (in_fire) begin
                        skid_d  = in_ent;
                        state_d = S_FULL;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign MEMR_o   = valid_o & main_q.mem[0];
    assign MEMW_o   = valid_o & main_q.mem[1];
    assign WB_o     = valid_o ? main_q.wb : '0;
    assign ALUout_o = main_q.alu;
    assign RS2_o    = main_q.rs2;
    assign RDaddr_o = main_q.rd;
    assign occ_o    = (state_q == S_FULL) ? 2'd2 : (state_q == S_ONE) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, streaming, backpressure, flush, gating, simultaneous fire, async reset.
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i, valid_i, ready_o, ready_i;
    logic [1:0]  MEM_i;
    logic [1:0]  WB_i;
    logic [31:0] ALUout_i, RS2_i;
    logic [4:0]  RDaddr_i;
    logic        valid_o, MEMR_o, MEMW_o;
    logic [1:0]  WB_o;
    logic [31:0] ALUout_o, RS2_o;
    logic [4:0]  RDaddr_o;
    logic [1:0]  occ_o;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.DATA_W(32), .ADDR_W(5), .WB_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .MEM_i(MEM_i), .WB_i(WB_i), .ALUout_i(ALUout_i), .RS2_i(RS2_i), .RDaddr_i(RDaddr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .MEMR_o(MEMR_o), .MEMW_o(MEMW_o), .WB_o(WB_o),
        .ALUout_o(ALUout_o), .RS2_o(RS2_o), .RDaddr_o(RDaddr_o), .occ_o(occ_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] mem, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        valid_i  = v;
        MEM_i    = mem;
        WB_i     = wb;
        ALUout_i = alu;
        RS2_i    = rs2;
        RDaddr_i = rd;
    endtask

    logic [31:0] ra, rb;
    logic [4:0]  rr;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'h0);
        #12;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_occ",   {30'b0, occ_o},   32'd0);
        chk("rst_memr",  {31'b0, MEMR_o},  32'd0);
        chk("rst_alu",   ALUout_o,         32'd0);
        step();
        rst_i = 1'b0;
        step();

        // streaming
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 2'b01, 32'h10 * (i + 1), 32'h100 + i, 5'(i + 1));
            step();
            chk("str_alu",  ALUout_o, 32'h10 * (i + 1));
            chk("str_rd",   {27'b0, RDaddr_o}, 32'(i + 1));
            chk("str_occ",  {30'b0, occ_o}, 32'd1);
            chk("str_memr", {31'b0, MEMR_o}, 32'd1);
            chk("str_wb",   {30'b0, WB_o}, 32'd1);
        end
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'h0);
        step();
        chk("str_drain_occ", {30'b0, occ_o}, 32'd0);

        // backpressure
        ready_i = 1'b0;
        drive(1'b1, 2'b00, 2'b00, 32'hA, 32'h0, 5'd4);
        step();
        chk("bp_a_occ", {30'b0, occ_o}, 32'd1);
        drive(1'b1, 2'b00, 2'b00, 32'hB, 32'h0, 5'd5);
        step();
        chk("bp_full_occ",   {30'b0, occ_o}, 32'd2);
        chk("bp_full_ready", {31'b0, ready_o}, 32'd0);
        chk("bp_full_alu",   ALUout_o, 32'hA);
        drive(1'b1, 2'b00, 2'b00, 32'hC, 32'h0, 5'd6);
        step();
        chk("bp_hold_occ", {30'b0, occ_o}, 32'd2);
        chk("bp_hold_alu", ALUout_o, 32'hA);
        ready_i = 1'b1;
        step();
        chk("bp_b_alu",   ALUout_o, 32'hB);
        chk("bp_b_ready", {31'b0, ready_o}, 32'd1);
        chk("bp_b_occ",   {30'b0, occ_o}, 32'd1);
        step();
        chk("bp_c_alu", ALUout_o, 32'hC);
        chk("bp_c_rd",  {27'b0, RDaddr_o}, 32'd6);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'h0);
        step();
        chk("bp_drain_occ", {30'b0, occ_o}, 32'd0);

        // flush while FULL holding a store
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 2'b00, 32'hD, 32'h55, 5'd7);
        step();
        chk("fl_memw_one", {31'b0, MEMW_o}, 32'd1);
        drive(1'b1, 2'b10, 2'b00, 32'hE, 32'h66, 5'd8);
        step();
        chk("fl_full_occ", {30'b0, occ_o}, 32'd2);
        drive(1'b1, 2'b10, 2'b01, 32'hF, 32'h77, 5'd9);
        flush_i = 1'b1;
        step();
        chk("fl_valid", {31'b0, valid_o}, 32'd0);
        chk("fl_memw",  {31'b0, MEMW_o}, 32'd0);
        chk("fl_occ",   {30'b0, occ_o}, 32'd0);
        // flush from EMPTY drops an input even though ready_o=1
        step();
        chk("fl_empty_occ", {30'b0, occ_o}, 32'd0);
        chk("fl_empty_wb",  {30'b0, WB_o}, 32'd0);
        flush_i = 1'b0;

        // gating
        drive(1'b0, 2'b11, 2'b11, 32'h99, 32'h99, 5'd3);
        step();
        chk("gt_memr", {31'b0, MEMR_o}, 32'd0);
        chk("gt_memw", {31'b0, MEMW_o}, 32'd0);
        chk("gt_wb",   {30'b0, WB_o}, 32'd0);

        // simultaneous in/out fire
        ready_i = 1'b1;
        drive(1'b1, 2'b01, 2'b10, 32'h1234, 32'h5678, 5'd10);
        step();
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rr = 5'($urandom_range(0, 31));
            drive(1'b1, 2'b01, 2'b10, ra, rb, rr);
            step();
            chk("sim_alu", ALUout_o, ra);
            chk("sim_rs2", RS2_o, rb);
            chk("sim_rd",  {27'b0, RDaddr_o}, {27'b0, rr});
            chk("sim_occ", {30'b0, occ_o}, 32'd1);
        end

        // asynchronous reset while FULL
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 2'b01, 32'h21, 32'h1, 5'd1);
        step();
        drive(1'b1, 2'b10, 2'b01, 32'h22, 32'h2, 5'd2);
        step();
        chk("ar_pre_occ", {30'b0, occ_o}, 32'd2);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'h0);
        rst_i = 1'b1;
        #2;
        chk("ar_valid", {31'b0, valid_o}, 32'd0);
        chk("ar_memw",  {31'b0, MEMW_o}, 32'd0);
        chk("ar_ready", {31'b0, ready_o}, 32'd1);
        chk("ar_occ",   {30'b0, occ_o}, 32'd0);
        chk("ar_alu",   ALUout_o, 32'd0);
        step();
        rst_i = 1'b0;
        step();
        chk("ar_post_memw", {31'b0, MEMW_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
